// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle matrix holds,
// branch-taken flushes, and a saturating stall-cycle performance counter.
module hazard_stall_ctrl #(
    parameter int MAT_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_r_select,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [1:0]       ex_w_select,
    input  logic             ex_mat_start,
    input  logic             mat_done,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             if_id_flush,
    output logic             mat_busy,
    output logic             mat_commit,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int LAT_W = $clog2(MAT_LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             run_q;
    logic             mat_start;
    logic             hold;
    logic             load_use;
    logic             branch;
    logic             lu_scalar;
    logic             lu_matrix;

    // Load-use hazard detection for scalar and matrix loads in EX.
    assign lu_scalar = ex_mem_read && (ex_w_select == 2'b01) && (ex_rd != 5'd0)
                     && ((ex_rd == id_rs1) || (id_rs2_r_select && (ex_rd == id_rs2)));
    assign lu_matrix = ex_mem_read && ex_w_select[1] && !id_rs2_r_select
                     && ((ex_w_select == 2'b11) || (ex_rd == id_rs2));

    // Next-state logic and combinational stall/flush decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        lat_d       = lat_q;
        mat_start   = 1'b0;
        hold        = 1'b0;
        load_use    = 1'b0;
        branch      = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        if_id_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_q && ex_mat_start) begin
                    state_d   = ST_BUSY;
                    lat_d     = LAT_W'(MAT_LAT - 1);
                    mat_start = 1'b1;
                end
            end
            ST_BUSY: begin
                lat_d = lat_q - 1'b1;
                // Leave on the cycle the countdown reaches zero, so the hold
                // window (start cycle plus BUSY) spans exactly MAT_LAT cycles.
                if (mat_done || (lat_q <= LAT_W'(1)))
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;   // a start here is ignored
            default:   state_d = ST_IDLE;
        endcase

        hold     = mat_start || (state_q == ST_BUSY);
        load_use = run_q && (state_q != ST_BUSY) && (lu_scalar || lu_matrix);
        // The older matrix op wins over a branch in its start cycle; the
        // branch unit re-presents the branch once EX is released.
        branch   = run_q && (state_q != ST_BUSY) && !mat_start && ex_branch_taken;

        if (hold) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else if (branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // State, latency countdown, registered state decodes and release gate.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: asynchronous reset clears every flop here; sequential state uses non-blocking assignments only.
        if (!rstn) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            run_q      <= 1'b0;
            mat_busy   <= 1'b0;
            mat_commit <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            run_q      <= 1'b1;
            mat_busy   <= (state_d == ST_BUSY);
            mat_commit <= (state_d == ST_COMMIT);
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed steps plus random
// traffic checked against a behavioural model of the sequencing rules.
module tb_hazard_stall_ctrl;

    localparam int MAT_LAT = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_rs2_r_select, ex_mem_read, ex_mat_start, mat_done, ex_branch_taken;
    logic [1:0]       ex_w_select;
    logic             pc_stall, if_id_stall, id_ex_stall, id_ex_flush, if_id_flush;
    logic             mat_busy, mat_commit;
    logic [CNT_W-1:0] stall_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_run;        // at least one clock seen since reset release
    bit m_busy;       // matrix op holding EX
    int m_busy_cyc;   // BUSY cycles completed by the current op
    bit m_commit;     // commit cycle
    int m_cnt;        // stall cycles, saturating
    bit e_pc, e_ifs, e_ids, e_idf, e_iff;

    hazard_stall_ctrl #(.MAT_LAT(MAT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs2_r_select(id_rs2_r_select),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_w_select(ex_w_select),
        .ex_mat_start(ex_mat_start), .mat_done(mat_done), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
        .mat_busy(mat_busy), .mat_commit(mat_commit), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic r2sel,
                         input logic [4:0] rd, input logic mr, input logic [1:0] ws,
                         input logic ms, input logic md, input logic bt);
        id_rs1 = rs1; id_rs2 = rs2; id_rs2_r_select = r2sel; ex_rd = rd;
        ex_mem_read = mr; ex_w_select = ws; ex_mat_start = ms; mat_done = md;
        ex_branch_taken = bt;
    endtask

    task automatic idle_inputs();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_run = 0; m_busy = 0; m_busy_cyc = 0; m_commit = 0; m_cnt = 0;
    endtask

    // Expected combinational outputs from the current inputs and model state.
    task automatic model_eval();
        bit start, lu, br, hold;
        start = m_run && !m_busy && !m_commit && ex_mat_start;
        hold  = start || m_busy;
        lu    = m_run && !m_busy &&
                ((ex_mem_read && ex_w_select == 2'b01 && ex_rd != 0 &&
                  (ex_rd == id_rs1 || (id_rs2_r_select && ex_rd == id_rs2))) ||
                 (ex_mem_read && ex_w_select[1] && !id_rs2_r_select &&
                  (ex_w_select == 2'b11 || ex_rd == id_rs2)));
        br    = m_run && !m_busy && !start && ex_branch_taken;
        e_pc  = hold || (!br && lu);
        e_ifs = e_pc;
        e_ids = hold;
        e_idf = !hold && (br || lu);
        e_iff = !hold && br;
    endtask

    // Advance the model across one rising edge.
    task automatic model_clock();
        bit start;
        if (!rstn) begin
            model_reset();
            return;
        end
        start = m_run && !m_busy && !m_commit && ex_mat_start;
        if (e_pc && m_cnt < CNT_MAX) m_cnt++;
        if (m_commit) begin
            m_commit = 0;
        end else if (m_busy) begin
            m_busy_cyc++;
            if (mat_done || m_busy_cyc >= MAT_LAT - 1) begin
                m_busy = 0;
                m_commit = 1;
            end
        end else if (start) begin
            m_busy = 1;
            m_busy_cyc = 0;
        end
        m_run = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_stall"},    {31'd0, pc_stall},    {31'd0, e_pc});
        check({tag, ".if_id_stall"}, {31'd0, if_id_stall}, {31'd0, e_ifs});
        check({tag, ".id_ex_stall"}, {31'd0, id_ex_stall}, {31'd0, e_ids});
        check({tag, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, e_idf});
        check({tag, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, e_iff});
        check({tag, ".mat_busy"},    {31'd0, mat_busy},    {31'd0, m_busy});
        check({tag, ".mat_commit"},  {31'd0, mat_commit},  {31'd0, m_commit});
        check({tag, ".stall_cnt"},   32'(stall_cnt),       32'(m_cnt));
    endtask

    // One clock: compare on the falling edge, update the model at the rising edge.
    task automatic cycle(input string tag, input bit chk);
        @(negedge clk);
        model_eval();
        if (chk) check_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    int base;

    initial begin
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle("reset", 1);
        rstn = 1'b1;

        // First cycle after release: hot inputs must not produce any output.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        cycle("post_release", 1);
        idle_inputs();
        cycle("idle", 1);

        // Scalar load-use on rs1, then the same with ex_rd = 0.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs1", 1);
        idle_inputs();
        cycle("lu_rs1_after", 1);
        check("lu_rs1_cnt", 32'(stall_cnt), 32'd1);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cycle("lu_rd0", 1);

        // rs2 compared only when it names a scalar register.
        drive(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs2_mat", 1);
        drive(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs2_scl", 1);

        // Matrix load-use: single register hit, all-register write, miss.
        drive(5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cycle("mlu_single", 1);
        drive(5'd0, 5'd2, 1'b0, 5'd3, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("mlu_all", 1);
        drive(5'd0, 5'd2, 1'b0, 5'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cycle("mlu_miss", 1);
        idle_inputs();
        cycle("idle2", 1);

        // Matrix timeout: start pulse, no done.
        base = m_cnt;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cycle("tmo_start", 1);
        idle_inputs();
        for (int i = 0; i < 10; i++) cycle("tmo", 1);
        check("tmo_cnt", 32'(stall_cnt), 32'(base + MAT_LAT));

        // Early done in the third BUSY cycle.
        base = m_cnt;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cycle("early_start", 1);
        idle_inputs();
        cycle("early_b1", 1);
        cycle("early_b2", 1);
        mat_done = 1'b1;
        cycle("early_b3", 1);
        mat_done = 1'b0;
        check("early_commit", {31'd0, mat_commit}, 32'd1);
        for (int i = 0; i < 3; i++) cycle("early_tail", 1);
        check("early_cnt", 32'(stall_cnt), 32'(base + 4));

        // Branch together with load-use: flush wins, no stall.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        cycle("br_lu", 1);
        // Branch in the start cycle and during BUSY: suppressed.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        cycle("br_start", 1);
        ex_mat_start = 1'b0;
        for (int i = 0; i < MAT_LAT + 1; i++) cycle("br_busy", 1);
        // Start during COMMIT is ignored; branch there flushes.
        idle_inputs();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        cycle("s_start", 1);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        cycle("s_done", 1);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        cycle("commit_ign", 1);
        idle_inputs();
        cycle("idle3", 1);

        // Reset in the fourth BUSY cycle.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cycle("rst_start", 1);
        ex_mat_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle("rst_busy", 1);
        rstn = 1'b0;
        model_reset();
        #1;
        model_eval();
        check_all("async_rst");
        cycle("rst_hold", 1);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) cycle("rst_after", 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0));
            cycle("rand", 1);
        end

        // Saturation: 2^CNT_W + 5 consecutive load-use stalls.
        drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 6; i++) cycle("sat_fill", 0);
        check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        cycle("sat_hold", 1);
        idle_inputs();
        cycle("sat_idle", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
